// File: rtl/window_linebuf.sv
// Sliding WIN x WIN window generator over a tagged raster pixel stream.
// WIN-1 cascaded line buffers, stalls on invalid beats, optional zero-padded border windows.
module window_linebuf #(
   parameter int unsigned          TAG_WIDTH    = 2,
   parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0,
   parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1,
   parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2,
   parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3,
   parameter int unsigned          PIX_W        = 8,
   parameter int unsigned          WIN          = 3,
   parameter int unsigned          ADDR_W       = 10,
   parameter int unsigned          PAD_MODE     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       reflesh,
   input  logic [31:0]                image_width,
   input  logic [PIX_W+TAG_WIDTH-1:0] data_in,
   output logic [PIX_W*WIN*WIN-1:0]   win_bus,
   output logic                       win_valid,
   output logic [TAG_WIDTH-1:0]       win_tag,
   output logic [ADDR_W-1:0]          win_row,
   output logic [ADDR_W-1:0]          win_col
);

   localparam int unsigned        NB      = WIN - 1;
   localparam int unsigned        DEPTH   = 1 << ADDR_W;
   localparam int unsigned        DW      = PIX_W * NB;
   localparam int unsigned        BW      = PIX_W * WIN * WIN;
   localparam logic [ADDR_W:0]    MAX_W   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0]  ROW_MAX = '1;

   logic [TAG_WIDTH-1:0] tag_c;
   logic [PIX_W-1:0]     pix_c;
   logic                 accept_c;
   logic                 first_c;
   logic                 last_col_c;
   logic [ADDR_W:0]      iw_c;
   logic [ADDR_W:0]      w_new_c;
   logic [ADDR_W:0]      w_cur_c;

   logic [ADDR_W-1:0]    row;
   logic [ADDR_W-1:0]    col;
   logic [ADDR_W:0]      w_lat;

   logic                 s1_valid;
   logic [PIX_W-1:0]     s1_pix;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [ADDR_W-1:0]    s1_row;
   logic [ADDR_W-1:0]    s1_col;

   logic [DW-1:0]        rd_ram_c;
   logic [DW-1:0]        rd_c;
   logic [DW-1:0]        wdata_c;
   logic                 byp;
   logic [DW-1:0]        byp_data;

   logic [BW-1:0]        win_q;
   logic [BW-1:0]        win_nx_c;
   logic [BW-1:0]        bus_c;
   logic                 s2_valid;
   logic [TAG_WIDTH-1:0] s2_tag;
   logic [ADDR_W-1:0]    s2_row;
   logic [ADDR_W-1:0]    s2_col;
   logic                 interior_c;

   logic                 unused_ok;

   assign tag_c    = data_in[TAG_WIDTH-1:0];
   assign pix_c    = data_in[TAG_WIDTH +: PIX_W];
   assign accept_c = (tag_c != INVALID_TAG);
   assign first_c  = (row == '0) && (col == '0);

   // Width is taken from the port only on the first pixel of a frame, else from the latch.
   assign iw_c       = image_width[ADDR_W:0];
   assign w_new_c    = ((iw_c == '0) || (iw_c > MAX_W)) ? MAX_W : iw_c;
   assign w_cur_c    = first_c ? w_new_c : w_lat;
   assign last_col_c = ({1'b0, col} == (w_cur_c - 1'b1));

   assign unused_ok = ^{image_width[31:ADDR_W+1], DATA_TAG0, DATA_TAG1};

   // Raster position counters and frame width latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row   <= '0;
         col   <= '0;
         w_lat <= MAX_W;
      end else if (reflesh) begin
         row   <= '0;
         col   <= '0;
         w_lat <= MAX_W;
      end else if (accept_c) begin
         if (first_c) w_lat <= w_new_c;
         if (tag_c == DATA_END_TAG) begin
            row <= '0;
            col <= '0;
         end else if (last_col_c) begin
            col <= '0;
            if (row != ROW_MAX) row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // S1: capture the accepted beat; bypass flags a read of the address being written this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_tag   <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
         byp      <= 1'b0;
         byp_data <= '0;
      end else if (reflesh) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_tag   <= '0;
         s1_row   <= '0;
         s1_col   <= '0;
         byp      <= 1'b0;
         byp_data <= '0;
      end else begin
         s1_valid <= accept_c;
         if (accept_c) begin
            s1_pix   <= pix_c;
            s1_tag   <= tag_c;
            s1_row   <= row;
            s1_col   <= col;
            byp      <= s1_valid && (s1_col == col);
            byp_data <= wdata_c;
         end
      end
   end

   // Line buffers: buffer k holds the line k+1 above the newest, shifted down in the S2 slot.
   for (genvar k = 0; k < NB; k++) begin : g_lb
      logic [PIX_W-1:0] mem [DEPTH];
      logic [PIX_W-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (s1_valid) mem[s1_col] <= wdata_c[k*PIX_W +: PIX_W];
         if (accept_c) rd_q <= mem[col];
      end

      assign rd_ram_c[k*PIX_W +: PIX_W] = rd_q;
   end

   assign rd_c    = byp ? byp_data : rd_ram_c;
   assign wdata_c = {rd_c[DW-PIX_W-1:0], s1_pix};

   // Next window: shift columns left, new column = buffered lines above the S1 pixel.
   always_comb begin
      win_nx_c = win_q;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN - 1; c++) begin
            win_nx_c[(r*WIN + c)*PIX_W +: PIX_W] = win_q[(r*WIN + c + 1)*PIX_W +: PIX_W];
         end
      end
      for (int r = 0; r < WIN - 1; r++) begin
         win_nx_c[(r*WIN + WIN - 1)*PIX_W +: PIX_W] = rd_c[(WIN - 2 - r)*PIX_W +: PIX_W];
      end
      win_nx_c[(WIN*WIN - 1)*PIX_W +: PIX_W] = s1_pix;
   end

   // S2: window registers, advanced only by accepted beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         win_q    <= '0;
         s2_tag   <= '0;
         s2_row   <= '0;
         s2_col   <= '0;
      end else if (reflesh) begin
         s2_valid <= 1'b0;
         win_q    <= '0;
         s2_tag   <= '0;
         s2_row   <= '0;
         s2_col   <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            win_q  <= win_nx_c;
            s2_tag <= s1_tag;
            s2_row <= s1_row;
            s2_col <= s1_col;
         end
      end
   end

   // Border taps (above row 0 / left of col 0, incl. stale previous-line columns) read as zero.
   always_comb begin
      bus_c = win_q;
      if (PAD_MODE != 0) begin
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
               if (((32'(s2_row) + 32'(r)) < 32'(WIN - 1)) ||
                   ((32'(s2_col) + 32'(c)) < 32'(WIN - 1))) begin
                  bus_c[(r*WIN + c)*PIX_W +: PIX_W] = '0;
               end
            end
         end
      end
   end

   assign interior_c = (32'(s2_row) >= 32'(WIN - 1)) && (32'(s2_col) >= 32'(WIN - 1));

   // Output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_valid <= 1'b0;
         win_bus   <= '0;
         win_tag   <= '0;
         win_row   <= '0;
         win_col   <= '0;
      end else if (reflesh) begin
         win_valid <= 1'b0;
         win_bus   <= '0;
         win_tag   <= '0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         win_valid <= s2_valid && ((PAD_MODE != 0) || interior_c);
         if (s2_valid) begin
            win_bus <= bus_c;
            win_tag <= s2_tag;
            win_row <= s2_row;
            win_col <= s2_col;
         end
      end
   end

endmodule

// File: tb/tb_window_linebuf.sv
// Scoreboard bench for window_linebuf: three instances (3x3 interior, 3x3 padded, 5x5 interior)
// share one stimulus stream; expected windows come from an image-indexed reference model.
module tb_window_linebuf;

   typedef struct {
      logic [199:0] bus;
      logic [1:0]   tag;
      logic [9:0]   row;
      logic [9:0]   col;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         reflesh;
   logic [31:0]  image_width;
   logic [9:0]   data_in;

   logic [71:0]  b0, b1;
   logic [199:0] b2;
   logic         v0, v1, v2;
   logic [1:0]   t0, t1, t2;
   logic [9:0]   r0, r1, r2, c0, c1, c2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mrow   = 0;
   int mcol   = 0;
   int mw     = 1024;
   logic [7:0] img [8][1024];
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   window_linebuf #(.WIN(3), .PAD_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .reflesh(reflesh), .image_width(image_width), .data_in(data_in),
      .win_bus(b0), .win_valid(v0), .win_tag(t0), .win_row(r0), .win_col(c0));
   window_linebuf #(.WIN(3), .PAD_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .reflesh(reflesh), .image_width(image_width), .data_in(data_in),
      .win_bus(b1), .win_valid(v1), .win_tag(t1), .win_row(r1), .win_col(c1));
   window_linebuf #(.WIN(5), .PAD_MODE(0)) u_dut2 (
      .clk(clk), .rst(rst), .reflesh(reflesh), .image_width(image_width), .data_in(data_in),
      .win_bus(b2), .win_valid(v2), .win_tag(t2), .win_row(r2), .win_col(c2));

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp_w(input logic [31:0] iw);
      int v;
      v = int'(iw[10:0]);
      return ((v == 0) || (v > 1024)) ? 1024 : v;
   endfunction

   // Window whose newest tap is (rn, cn); taps outside the image are zero.
   function automatic logic [199:0] mk_bus(input int win, input int rn, input int cn);
      logic [199:0] b;
      int rr, cc;
      b = '0;
      for (int r = 0; r < win; r++) begin
         for (int c = 0; c < win; c++) begin
            rr = rn - (win - 1 - r);
            cc = cn - (win - 1 - c);
            if (rr >= 0 && cc >= 0) b[((r*win)+c)*8 +: 8] = img[rr%8][cc];
         end
      end
      return b;
   endfunction

   task automatic send(input logic [7:0] pix, input logic [1:0] tg);
      exp_t e;
      @(posedge clk);
      #2;
      data_in = {pix, tg};
      if (reflesh) begin
         mrow = 0;
         mcol = 0;
      end else if (tg != 2'd0) begin
         if (mrow == 0 && mcol == 0) mw = clamp_w(image_width);
         img[mrow%8][mcol] = pix;
         e.tag = tg;
         e.row = 10'(mrow);
         e.col = 10'(mcol);
         e.cyc = cyc + 3;
         e.bus = mk_bus(3, mrow, mcol);
         q1.push_back(e);
         if (mrow >= 2 && mcol >= 2) q0.push_back(e);
         if (mrow >= 4 && mcol >= 4) begin
            e.bus = mk_bus(5, mrow, mcol);
            q2.push_back(e);
         end
         if (tg == 2'd3) begin
            mrow = 0;
            mcol = 0;
         end else if (mcol == mw - 1) begin
            mcol = 0;
            if (mrow != 1023) mrow++;
         end else begin
            mcol++;
         end
      end
   endtask

   task automatic send_frame(input int iw, input int npix, input int gaps, input bit ramp,
                             input int first, input bit with_end);
      logic [7:0] pix;
      logic [1:0] tg;
      image_width = 32'(iw);
      for (int k = 0; k < npix; k++) begin
         if (ramp) pix = 8'(mrow*16 + mcol);
         else if (first >= 0 && k == 0) pix = 8'(first);
         else pix = 8'($urandom);
         if (with_end && k == npix - 1) tg = 2'd3;
         else tg = (k % 2 == 1) ? 2'd2 : 2'd1;
         send(pix, tg);
         if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) send(8'h00, 2'd0);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 12; k++) begin
         if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
         send(8'h00, 2'd0);
      end
   endtask

   task automatic mon(input int i, input logic v, input logic [199:0] bus, input logic [1:0] tg,
                      input logic [9:0] rw, input logic [9:0] cl);
      exp_t e;
      int n;
      case (i)
         0: n = q0.size();
         1: n = q1.size();
         default: n = q2.size();
      endcase
      if (n > 0) begin
         case (i)
            0: e = q0[0];
            1: e = q1[0];
            default: e = q2[0];
         endcase
      end
      if (v) begin
         if (n == 0) begin
            check($sformatf("spurious_valid%0d", i), 256'(v), 256'(0));
         end else begin
            case (i)
               0: void'(q0.pop_front());
               1: void'(q1.pop_front());
               default: void'(q2.pop_front());
            endcase
            check($sformatf("latency%0d", i), 256'(cyc), 256'(e.cyc));
            check($sformatf("row%0d", i), 256'(rw), 256'(e.row));
            check($sformatf("col%0d", i), 256'(cl), 256'(e.col));
            check($sformatf("tag%0d", i), 256'(tg), 256'(e.tag));
            check($sformatf("bus%0d", i), 256'(bus), 256'(e.bus));
         end
      end else if (n > 0 && e.cyc < cyc) begin
         check($sformatf("missing_valid%0d", i), 256'(v), 256'(1));
         case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
         endcase
      end
   endtask

   always @(negedge clk) begin
      mon(0, v0, 200'(b0), t0, r0, c0);
      mon(1, v1, 200'(b1), t1, r1, c1);
      mon(2, v2, b2, t2, r2, c2);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      reflesh = 1'b0;
      image_width = 32'd0;
      data_in = 10'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid0", 256'(v0), 256'(0));
      check("rst_bus0", 256'(b0), 256'(0));
      check("rst_row0", 256'(r0), 256'(0));
      check("rst_col0", 256'(c0), 256'(0));
      check("rst_tag0", 256'(t0), 256'(0));
      check("rst_valid1", 256'(v1), 256'(0));
      check("rst_bus2", 256'(b2), 256'(0));
      @(posedge clk);
      #2;
      rst = 1'b1;

      // 4x4 ramp without and with gaps; 5x5 instance must stay silent (W < WIN)
      send_frame(4, 16, 0, 1'b1, -1, 1'b1);
      drain();
      send_frame(4, 16, 1, 1'b1, -1, 1'b1);
      drain();

      // padded first pixel 0x55, END mid-frame at (1,3), back-to-back W=5 frame
      send_frame(4, 8, 0, 1'b0, 8'h55, 1'b1);
      send_frame(5, 15, 2, 1'b0, -1, 1'b1);
      drain();

      // single-column image: every beat rewrites the same line-buffer address
      send_frame(1, 5, 0, 1'b0, -1, 1'b1);
      send_frame(1, 5, 2, 1'b0, -1, 1'b1);
      drain();

      // asynchronous reset right after (2,1) is accepted
      send_frame(4, 10, 0, 1'b0, -1, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_valid1", 256'(v1), 256'(1));
      data_in = 10'd0;
      rst = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
      mrow = 0;
      mcol = 0;
      #1;
      check("arst_valid1", 256'(v1), 256'(0));
      check("arst_bus1", 256'(b1), 256'(0));
      check("arst_row1", 256'(r1), 256'(0));
      check("arst_col1", 256'(c1), 256'(0));
      check("arst_tag1", 256'(t1), 256'(0));
      @(posedge clk);
      #2;
      rst = 1'b1;
      send_frame(4, 6, 0, 1'b1, -1, 1'b1);
      drain();

      // synchronous clear drops the coincident beat
      reflesh = 1'b1;
      send(8'hAA, 2'd1);
      @(posedge clk);
      #1;
      reflesh = 1'b0;
      data_in = 10'd0;
      check("refl_valid1", 256'(v1), 256'(0));
      check("refl_bus1", 256'(b1), 256'(0));
      check("refl_col1", 256'(c1), 256'(0));
      send_frame(4, 10, 0, 1'b1, -1, 1'b1);
      drain();

      // width 0 and 2000 both clamp to 1024
      send_frame(0, 4*1024 + 5, 0, 1'b0, -1, 1'b1);
      drain();
      send_frame(2000, 1024 + 3, 0, 1'b0, -1, 1'b1);
      drain();

      check("q0_empty", 256'(q0.size()), 256'(0));
      check("q1_empty", 256'(q1.size()), 256'(0));
      check("q2_empty", 256'(q2.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
